fpu_put_z: RTL and testbench

- Output-side packer/transmitter for the FPU datapath. It accepts one unpacked result per handshake (sign, unbiased exponent, 24-bit mantissa with explicit hidden bit, NaN flag).
- It packs the result into an IEEE-754 single-precision word and presents it on a strobe/acknowledge output port.
- Upstream, the FPU core's normalise/round stage hands results to this block; downstream is the consumer of output_z.
- It is the counterpart of the operand-fetch state machine at the FPU front end.

---
 rtl/fpu_put_z.sv | 122 ++++++++++++
 tb/tb_fpu_put_z.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_put_z.sv
// Output stage of the FPU: captures one unpacked result and packs it into a binary32 word.
// It then holds the word on a strobe/acknowledge port until the consumer accepts it.
module fpu_put_z (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_s,
  input  logic [9:0]  in_e,
  input  logic [23:0] in_m,
  input  logic        in_nan,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [3:0]  state_out
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_PACK  = 4'd1;
  localparam logic [3:0] ST_PUT_Z = 4'd2;

  logic [3:0]  state_q, state_d;
  logic        s_q, s_d;
  logic [9:0]  e_q, e_d;
  logic [23:0] m_q, m_d;
  logic        nan_q, nan_d;
  logic        in_ack_q, in_ack_d;
  logic [31:0] z_q, z_d;
  logic        z_stb_q, z_stb_d;

  logic [9:0]  biased_e;
  logic [31:0] packed_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= 1'b0;
      e_q      <= 10'd0;
      m_q      <= 24'd0;
      nan_q    <= 1'b0;
      in_ack_q <= 1'b1;
      z_q      <= 32'h0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      nan_q    <= nan_d;
      in_ack_q <= in_ack_d;
      z_q      <= z_d;
      z_stb_q  <= z_stb_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = (in_stb && in_ack_q) ? ST_PACK : ST_IDLE;
      ST_PACK:  state_d = ST_PUT_Z;
      ST_PUT_Z: state_d = (z_stb_q && output_z_ack) ? ST_IDLE : ST_PUT_Z;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Exponent range tests are signed: 10'h3FF is -1, not a large overflow.
  always_comb begin
    biased_e = e_q + 10'd127;
    if (nan_q)
      packed_z = 32'h7FC00000;
    else if ($signed(e_q) > 10'sd127)
      packed_z = {s_q, 8'hFF, 23'h0};
    else if ($signed(e_q) < -10'sd126)
      packed_z = {s_q, 31'h0};
    else if (($signed(e_q) == -10'sd126) && !m_q[23])
      packed_z = {s_q, 8'h00, m_q[22:0]};
    else
      packed_z = {s_q, biased_e[7:0], m_q[22:0]};
  end

  always_comb begin
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    nan_d    = nan_q;
    in_ack_d = in_ack_q;
    z_d      = z_q;
    z_stb_d  = z_stb_q;
    case (state_q)
      ST_IDLE: begin
        in_ack_d = 1'b1;
        if (in_stb && in_ack_q) begin
          s_d      = in_s;
          e_d      = in_e;
          m_d      = in_m;
          nan_d    = in_nan;
          in_ack_d = 1'b0;
        end
      end
      ST_PACK: begin
        z_d     = packed_z;
        z_stb_d = 1'b1;
      end
      ST_PUT_Z: begin
        if (z_stb_q && output_z_ack) begin
          z_stb_d  = 1'b0;
          in_ack_d = 1'b1;
        end
      end
      default: begin
        in_ack_d = 1'b1;
        z_stb_d  = 1'b0;
      end
    endcase
  end

  assign in_ack       = in_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_fpu_put_z.sv
// Directed bench for fpu_put_z: packing table, backpressure, back-to-back and async reset.
module tb_fpu_put_z;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_s;
  logic [9:0]  in_e;
  logic [23:0] in_m;
  logic        in_nan;
  logic        in_stb;
  logic        in_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic [3:0]  state_out;

  int checks = 0;
  int failures = 0;

  fpu_put_z dut (
    .clk(clk), .rst(rst), .in_s(in_s), .in_e(in_e), .in_m(in_m), .in_nan(in_nan),
    .in_stb(in_stb), .in_ack(in_ack), .output_z(output_z), .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [23:0] m;
    logic        nan;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", {31'd0, in_ack}, 32'd1);
  endtask

  // Full single transaction with per-edge timing checks.
  task automatic run_vec(input vec_t v, input int idx);
    wait_ready();
    @(negedge clk);
    in_s = v.s; in_e = v.e; in_m = v.m; in_nan = v.nan; in_stb = 1'b1;
    @(posedge clk); #1;
    chk("hs_state", {28'd0, state_out}, 32'd1);
    chk("hs_stb", {31'd0, output_z_stb}, 32'd0);
    in_stb = 1'b0;
    @(posedge clk); #1;
    chk("pack_stb", {31'd0, output_z_stb}, 32'd1);
    chk("pack_z", output_z, v.z);
    $display("vec %0d: e=%h m=%h nan=%0d s=%0d -> z=%h (want %h)", idx, v.e, v.m, v.nan, v.s, output_z, v.z);
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    chk("ack_stb", {31'd0, output_z_stb}, 32'd0);
    chk("ack_in_ack", {31'd0, in_ack}, 32'd1);
    chk("ack_state", {28'd0, state_out}, 32'd0);
    chk("ack_z_hold", output_z, v.z);
    output_z_ack = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 10'h000, 24'h800000, 1'b0, 32'h3F800000};
    vecs[1]  = '{1'b1, 10'h001, 24'hC00000, 1'b0, 32'hC0400000};
    vecs[2]  = '{1'b0, 10'h080, 24'h800000, 1'b0, 32'h7F800000};
    vecs[3]  = '{1'b0, 10'h3FF, 24'h800000, 1'b0, 32'h3F000000};
    vecs[4]  = '{1'b0, 10'h382, 24'h400000, 1'b0, 32'h00400000};
    vecs[5]  = '{1'b1, 10'h382, 24'h000000, 1'b0, 32'h80000000};
    vecs[6]  = '{1'b0, 10'h37E, 24'hC00000, 1'b0, 32'h00000000};
    vecs[7]  = '{1'b1, 10'h000, 24'h800000, 1'b1, 32'h7FC00000};
    vecs[8]  = '{1'b0, 10'h07F, 24'h800000, 1'b0, 32'h7F000000};
    vecs[9]  = '{1'b0, 10'h382, 24'h800000, 1'b0, 32'h00800000};
    vecs[10] = '{1'b1, 10'h381, 24'hFFFFFF, 1'b0, 32'h80000000};
    vecs[11] = '{1'b1, 10'h1FF, 24'h800000, 1'b0, 32'hFF800000};

    rst = 1'b1; in_s = 0; in_e = 0; in_m = 0; in_nan = 0; in_stb = 0; output_z_ack = 0;
    #1;
    chk("rst_state", {28'd0, state_out}, 32'd0);
    chk("rst_in_ack", {31'd0, in_ack}, 32'd1);
    chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Ack outside put_z must be ignored.
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    chk("stray_ack_state", {28'd0, state_out}, 32'd0);
    chk("stray_ack_stb", {31'd0, output_z_stb}, 32'd0);
    output_z_ack = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure: pulse in_stb with new data while the consumer stalls.
    wait_ready();
    @(negedge clk);
    in_s = vecs[1].s; in_e = vecs[1].e; in_m = vecs[1].m; in_nan = 1'b0; in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    @(posedge clk); #1;
    chk("bp_start_z", output_z, 32'hC0400000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_stb = c[0]; in_e = 10'(c); in_m = 24'h800000; in_s = 1'b0;
      @(posedge clk); #1;
      chk("bp_z", output_z, 32'hC0400000);
      chk("bp_stb", {31'd0, output_z_stb}, 32'd1);
      chk("bp_in_ack", {31'd0, in_ack}, 32'd0);
      chk("bp_state", {28'd0, state_out}, 32'd2);
      $display("bp cycle %0d: z=%h stb=%0d in_ack=%0d state=%0d", c, output_z, output_z_stb, in_ack, state_out);
    end
    @(negedge clk);
    in_stb = 1'b0; output_z_ack = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_stb", {31'd0, output_z_stb}, 32'd0);
    chk("bp_rel_in_ack", {31'd0, in_ack}, 32'd1);
    chk("bp_rel_state", {28'd0, state_out}, 32'd0);
    output_z_ack = 1'b0;

    // Back-to-back: one result every 3 cycles with both handshakes held high.
    begin
      int idx_in = 1;
      int idx_out = 0;
      @(negedge clk);
      in_s = vecs[0].s; in_e = vecs[0].e; in_m = vecs[0].m; in_nan = vecs[0].nan;
      in_stb = 1'b1; output_z_ack = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
        @(posedge clk); #1;
        if (state_out == 4'd1) begin
          if (idx_in < 3) begin
            in_s = vecs[idx_in].s; in_e = vecs[idx_in].e;
            in_m = vecs[idx_in].m; in_nan = vecs[idx_in].nan;
            idx_in++;
          end else begin
            in_stb = 1'b0;
          end
        end
        if (output_z_stb) begin
          if (idx_out < 3) begin
            chk("b2b_z", output_z, vecs[idx_out].z);
            chk("b2b_cycle", 32'(cyc), 32'(1 + 3 * idx_out));
            $display("b2b result %0d at cycle %0d: z=%h", idx_out, cyc, output_z);
          end
          idx_out++;
        end
      end
      chk("b2b_count", 32'(idx_out), 32'd3);
      in_stb = 1'b0; output_z_ack = 1'b0;
    end

    // Async reset while parked in put_z, between clock edges.
    wait_ready();
    @(negedge clk);
    in_s = vecs[8].s; in_e = vecs[8].e; in_m = vecs[8].m; in_nan = 1'b0; in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_state", {28'd0, state_out}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("arst_in_ack", {31'd0, in_ack}, 32'd1);
    chk("arst_state", {28'd0, state_out}, 32'd0);
    chk("arst_z", output_z, 32'h0);
    $display("async reset: z=%h stb=%0d in_ack=%0d state=%0d", output_z, output_z_stb, in_ack, state_out);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
